serial_sub: RTL and testbench

Bit-serial two's-complement subtractor computing `a - b - bin` one bit per clock, LSB first, through a single full-subtractor cell and a borrow flip-flop. It is the subtraction counterpart of the combinational full-adder datapath: the same ripple structure, folded in time. A start/busy/done handshake gives small area at the cost of WIDTH-cycle latency, and suits slow arithmetic paths and control units that sequence operands.

---
 rtl/serial_sub.sv | 128 ++++++++++++
 tb/tb_serial_sub.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_sub.sv
// serial_sub: bit-serial two's-complement subtractor computing a - b - bin.
// One full-subtractor cell and a borrow flip-flop process one bit per clock,
// LSB first; a start/busy/done handshake sequences each WIDTH-cycle operation.
module serial_sub #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             br_q, br_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;
    logic             done_q, done_d;

    logic bit_x, bit_y, diff_bit, borrow_nxt, accept;

    // Full-subtractor cell on the current LSBs of the operand shift registers.
    assign bit_x      = sa_q[0];
    assign bit_y      = sb_q[0];
    assign diff_bit   = bit_x ^ bit_y ^ br_q;
    assign borrow_nxt = (~bit_x & bit_y) | (~(bit_x ^ bit_y) & br_q);

    // A new request is only taken when no operation is in flight.
    assign accept = start && ((state_q == IDLE) || (state_q == DONE));

    // Next-state logic: sequencing, bit-serial shifting and result capture.
    always_comb begin
        state_d = state_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        br_d    = br_q;
        diff_d  = diff_q;
        bout_d  = bout_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                sa_d  = sa_q >> 1;
                sb_d  = sb_q >> 1;
                res_d = {diff_bit, res_q[WIDTH-1:1]};
                br_d  = borrow_nxt;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    // Publish the complete word, including this final bit, in one step.
                    state_d = DONE;
                    diff_d  = {diff_bit, res_q[WIDTH-1:1]};
                    bout_d  = borrow_nxt;
                    done_d  = 1'b1;
                end
            end
            DONE: begin
                state_d = start ? RUN : IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (accept) begin
            sa_d  = a;
            sb_d  = b;
            br_d  = bin;
            cnt_d = '0;
            res_d = '0;
        end
    end

    // State and datapath registers; reset clears everything and abandons any op.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sa_q    <= '0;
            sb_q    <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            br_q    <= 1'b0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            br_q    <= br_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
            done_q  <= done_d;
        end
    end

    assign busy = (state_q == RUN);
    assign done = done_q;
    assign diff = diff_q;
    assign bout = bout_q;

endmodule

// File: tb/tb_serial_sub.sv
// Testbench for serial_sub: directed scenarios at WIDTH=8 plus random traffic
// at WIDTH=8 and WIDTH=13, with a result scoreboard per instance.
module tb_serial_sub;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        start8, bin8, busy8, done8, bout8;
    logic [7:0]  a8, b8, diff8;
    logic        start13, bin13, busy13, done13, bout13;
    logic [12:0] a13, b13, diff13;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [8:0]  q8[$];
    logic [13:0] q13[$];
    logic [8:0]  e8;
    logic [13:0] e13;
    int   dcnt8 = 0, dcnt13 = 0;
    int   brun8 = 0, brun13 = 0;
    logic pdone8 = 1'b0, pdone13 = 1'b0;
    int   tdone8 = 0;

    serial_sub #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .bin(bin8),
        .busy(busy8), .done(done8), .diff(diff8), .bout(bout8)
    );

    serial_sub #(.WIDTH(13)) dut13 (
        .clk(clk), .rst_n(rst_n), .start(start13), .a(a13), .b(b13), .bin(bin13),
        .busy(busy13), .done(done13), .diff(diff13), .bout(bout13)
    );

    always @(posedge clk) cyc = cyc + 1;

    // Scoreboard and busy-width monitor for the 8-bit instance.
    always @(negedge clk) begin
        if (rst_n !== 1'b1) begin
            brun8  = 0;
            pdone8 = 1'b0;
        end else begin
            if (done8 === 1'b1) begin
                dcnt8++;
                checks++;
                if (q8.size() == 0) begin
                    errors++;
                    $display("FAIL done8_unexpected got=%h expected=no_done", {bout8, diff8});
                end else begin
                    e8 = q8.pop_front();
                    if ({bout8, diff8} !== e8) begin
                        errors++;
                        $display("FAIL result8 got=%h expected=%h", {bout8, diff8}, e8);
                    end
                end
                checks++;
                if (pdone8 === 1'b1) begin
                    errors++;
                    $display("FAIL done8_width got=2+ cycles expected=1");
                end
            end
            pdone8 = done8;
            if (busy8 === 1'b1) brun8++;
            else if (brun8 != 0) begin
                checks++;
                if (brun8 != 8) begin
                    errors++;
                    $display("FAIL busy8_width got=%0d expected=8", brun8);
                end
                brun8 = 0;
            end
        end
    end

    // Scoreboard and busy-width monitor for the 13-bit instance.
    always @(negedge clk) begin
        if (rst_n !== 1'b1) begin
            brun13  = 0;
            pdone13 = 1'b0;
        end else begin
            if (done13 === 1'b1) begin
                dcnt13++;
                checks++;
                if (q13.size() == 0) begin
                    errors++;
                    $display("FAIL done13_unexpected got=%h expected=no_done", {bout13, diff13});
                end else begin
                    e13 = q13.pop_front();
                    if ({bout13, diff13} !== e13) begin
                        errors++;
                        $display("FAIL result13 got=%h expected=%h", {bout13, diff13}, e13);
                    end
                end
                checks++;
                if (pdone13 === 1'b1) begin
                    errors++;
                    $display("FAIL done13_width got=2+ cycles expected=1");
                end
            end
            pdone13 = done13;
            if (busy13 === 1'b1) brun13++;
            else if (brun13 != 0) begin
                checks++;
                if (brun13 != 13) begin
                    errors++;
                    $display("FAIL busy13_width got=%0d expected=13", brun13);
                end
                brun13 = 0;
            end
        end
    end

    function automatic logic [8:0] ref8(logic [7:0] x, logic [7:0] y, logic bi);
        return {1'b0, x} - {1'b0, y} - 9'(bi);
    endfunction

    function automatic logic [13:0] ref13(logic [12:0] x, logic [12:0] y, logic bi);
        return {1'b0, x} - {1'b0, y} - 14'(bi);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive a one-cycle start; optionally record the expected result.
    task automatic op8(input logic [7:0] x, input logic [7:0] y, input logic bi, input bit push);
        start8 = 1'b1; a8 = x; b8 = y; bin8 = bi;
        if (push) q8.push_back(ref8(x, y, bi));
        tick();
        start8 = 1'b0;
    endtask

    task automatic op13(input logic [12:0] x, input logic [12:0] y, input logic bi);
        start13 = 1'b1; a13 = x; b13 = y; bin13 = bi;
        q13.push_back(ref13(x, y, bi));
        tick();
        start13 = 1'b0;
    endtask

    task automatic wait_done8(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (done8 === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s_timeout done8=%b expected=1", name, done8);
        end
        tdone8 = cyc;
    endtask

    task automatic wait_done13(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (done13 === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s_timeout done13=%b expected=1", name, done13);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start8 = 1'b0; a8 = '0; b8 = '0; bin8 = 1'b0;
        start13 = 1'b0; a13 = '0; b13 = '0; bin13 = 1'b0;
        tick();
        tick();
        checks++;
        if ({busy8, done8, bout8, diff8} !== 11'd0) begin
            errors++;
            $display("FAIL reset8 got busy=%b done=%b bout=%b diff=%h expected all 0", busy8, done8, bout8, diff8);
        end
        checks++;
        if ({busy13, done13, bout13, diff13} !== 16'd0) begin
            errors++;
            $display("FAIL reset13 got busy=%b done=%b bout=%b diff=%h expected all 0", busy13, done13, bout13, diff13);
        end
        rst_n = 1'b1;
        tick();
        op8(8'h5A, 8'h23, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (busy8 !== 1'b1 || done8 !== 1'b0) begin
                errors++;
                $display("FAIL first_run_cycle%0d got busy=%b done=%b expected busy=1 done=0", i, busy8, done8);
            end
            tick();
        end
        checks++;
        if (busy8 !== 1'b0 || done8 !== 1'b1 || diff8 !== 8'h37 || bout8 !== 1'b0) begin
            errors++;
            $display("FAIL first_done got busy=%b done=%b diff=%h bout=%b expected 0 1 37 0", busy8, done8, diff8, bout8);
        end
        tick();
        checks++;
        if (done8 !== 1'b0 || diff8 !== 8'h37) begin
            errors++;
            $display("FAIL first_hold got done=%b diff=%h expected done=0 diff=37", done8, diff8);
        end
    endtask

    task automatic test_borrow();
        logic [7:0] xs[3] = '{8'h10, 8'h00, 8'hFF};
        logic [7:0] ys[3] = '{8'h20, 8'h00, 8'hFF};
        logic       bs[3] = '{1'b0, 1'b1, 1'b0};
        logic [8:0] ex[3] = '{9'h1F0, 9'h1FF, 9'h000};
        for (int i = 0; i < 3; i++) begin
            op8(xs[i], ys[i], bs[i], 1'b1);
            wait_done8("borrow");
            checks++;
            if ({bout8, diff8} !== ex[i]) begin
                errors++;
                $display("FAIL borrow%0d got=%h expected=%h", i, {bout8, diff8}, ex[i]);
            end
        end
    endtask

    task automatic test_start_busy();
        int d0;
        tick();
        d0 = dcnt8;
        op8(8'h80, 8'h01, 1'b0, 1'b1);
        tick();
        tick();
        start8 = 1'b1; a8 = 8'h00; b8 = 8'hFF; bin8 = 1'b0;
        tick();
        start8 = 1'b0;
        wait_done8("start_busy");
        checks++;
        if (diff8 !== 8'h7F || bout8 !== 1'b0) begin
            errors++;
            $display("FAIL start_busy_result got diff=%h bout=%b expected 7F 0", diff8, bout8);
        end
        repeat (12) tick();
        checks++;
        if (dcnt8 != d0 + 1) begin
            errors++;
            $display("FAIL start_busy_count got=%0d dones expected=1", dcnt8 - d0);
        end
    endtask

    task automatic test_reset_mid();
        int d0;
        op8(8'h33, 8'h11, 1'b0, 1'b0);
        repeat (4) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checks++;
        if ({busy8, done8, bout8, diff8} !== 11'd0) begin
            errors++;
            $display("FAIL reset_mid got busy=%b done=%b bout=%b diff=%h expected all 0", busy8, done8, bout8, diff8);
        end
        d0 = dcnt8;
        repeat (12) tick();
        checks++;
        if (dcnt8 != d0 || diff8 !== 8'h00) begin
            errors++;
            $display("FAIL reset_mid_nodone got dones=%0d diff=%h expected 0 00", dcnt8 - d0, diff8);
        end
        op8(8'h09, 8'h04, 1'b0, 1'b1);
        wait_done8("reset_mid_fresh");
        checks++;
        if (diff8 !== 8'h05 || bout8 !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_fresh got diff=%h bout=%b expected 05 0", diff8, bout8);
        end
    endtask

    task automatic test_back_to_back();
        int t1;
        tick();
        op8(8'h40, 8'h01, 1'b0, 1'b1);
        wait_done8("b2b_first");
        t1 = tdone8;
        op8(8'h03, 8'h05, 1'b1, 1'b1);
        wait_done8("b2b_second");
        checks++;
        if (tdone8 - t1 != 9) begin
            errors++;
            $display("FAIL b2b_spacing got=%0d expected=9", tdone8 - t1);
        end
        checks++;
        if (diff8 !== 8'hFD || bout8 !== 1'b1) begin
            errors++;
            $display("FAIL b2b_result got diff=%h bout=%b expected FD 1", diff8, bout8);
        end
    endtask

    task automatic rand8();
        for (int n = 0; n < 1000; n++) begin
            op8(8'($urandom), 8'($urandom), 1'($urandom), 1'b1);
            wait_done8("rand8");
            repeat ($urandom_range(0, 3)) tick();
        end
    endtask

    task automatic rand13();
        for (int n = 0; n < 1000; n++) begin
            op13(13'($urandom), 13'($urandom), 1'($urandom));
            wait_done13("rand13");
            repeat ($urandom_range(0, 3)) tick();
        end
    endtask

    task automatic test_random();
        tick();
        fork
            rand8();
            rand13();
        join
        repeat (3) tick();
        checks++;
        if (q8.size() != 0 || q13.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got q8=%0d q13=%0d expected 0 0", q8.size(), q13.size());
        end
    endtask

    initial begin
        rst_n = 1'b0;
        test_reset();
        test_borrow();
        test_start_busy();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
